tuner_ctrl: RTL and testbench
=============================

TUNER_CTRL -- requirements
Module: tuner_ctrl

Interface
REQ-001 Parameters: width_dds, 32, DDS phase-constant width; R1, 250, clocks per base-band enable; R2, 30, base-band enables per audio enable; SETTLE, 16, audio samples muted after any K change; DWELL, 64, audio samples per level measurement (power of two, >=2); K_RESET, 0, K after reset.
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 en_b  out  1  base-band clock enable, one-cycle pulse every R1 clocks.
REQ-005 en_a  out  1  audio clock enable, one-cycle pulse every R1*R2 clocks, coincident with an en_b pulse.
REQ-006 tune_req  in  1  single-cycle request to load tune_K.
REQ-007 tune_K  in  width_dds  direct tuning phase constant.
REQ-008 scan_up / scan_down  in  1 each  single-cycle scan requests.
REQ-009 step  in  width_dds  scan increment, unsigned; K_min, K_max  in  width_dds each  scan band limits, unsigned.
REQ-010 level  in  16  unsigned signal-quality sample, valid on en_a; threshold  in  16  unsigned station-detect level.
REQ-011 K  out  width_dds  phase constant driven to the DDS; busy, mute, locked, scan_fail  out  1 each.

Function
REQ-012 Divider: counter cb 0..R1-1 increments every clock, wraps to 0; en_b=1 in the cycle cb==R1-1.
REQ-013 Counter ca 0..R2-1 advances on en_b, wraps to 0; en_a=1 in the cycle en_b==1 and ca==R2-1.
REQ-014 FSM states: IDLE, SETTLE, MEASURE, STEP; all timing counters (settle, dwell) advance only on en_a.
REQ-015 K is a register; it changes only in the cycle the FSM enters SETTLE (load or step), never otherwise.
REQ-016 tune_req accepted in any state, priority over scan requests same cycle: K<=tune_K, start_K<=tune_K, mode<=DIRECT, enter SETTLE; aborts any scan in progress, locked<=0, no scan_fail.
REQ-017 scan_up xor scan_down accepted only in IDLE and only if K_min<K_max; both high or K_min>=K_max: ignored; scan requests outside IDLE: ignored.
REQ-018 Scan accept: start_K<=K, direction latched, wrap flag cleared, locked<=0, enter STEP.
REQ-019 STEP (one cycle): up: next=K+step computed width_dds+1 bits, if next>K_max then next=K_min and wrap<=1; down: if K<K_min+step (width_dds+1 bits) then next=K_max and wrap<=1, else next=K-step.
REQ-020 STEP termination: if wrap (after update) and next has reached or passed start_K (up: next>=start_K; down: next<=start_K): K<=start_K, scan_fail pulses 1 cycle, mode<=DIRECT, enter SETTLE; else K<=next, enter SETTLE.
REQ-021 SETTLE: mute=1; exits after SETTLE en_a pulses counted from entry; DIRECT mode -> IDLE; scan mode -> MEASURE with accumulator cleared.
REQ-022 MEASURE: mute=1; on each en_a acc<=acc+level, acc width 16+log2(DWELL), no overflow possible; after DWELL samples compare (acc>>log2(DWELL))>=threshold.
REQ-023 Compare true: locked<=1, enter IDLE; false: enter STEP.
REQ-024 locked set only by REQ-023; cleared by tune_req or scan accept; after a direct tune locked=0.
REQ-025 busy=1 in every state except IDLE; mute=1 in SETTLE and MEASURE and STEP, 0 in IDLE.
REQ-026 Outputs registered except en_b/en_a (decode of registered counters permitted); no combinational path inputs->outputs.
REQ-027 tune_req during en_a cycle in SETTLE/MEASURE: tune wins, counters restart, that en_a sample not accumulated.

Reset
REQ-028 Reset asserted (low) asynchronously forces: cb=0, ca=0, en_b=0, en_a=0, K=K_RESET, state IDLE, acc=0, wrap=0, busy=0, mute=0, locked=0, scan_fail=0; deassertion synchronous to clk by the integrating system.
REQ-029 Reset mid-scan abandons the scan with no scan_fail pulse; first en_b occurs R1 clocks after release.

Verification (R1=4, R2=3, SETTLE=2, DWELL=4, width_dds=8, K_RESET=10)
REQ-030 Release reset, run 48 clocks -> en_b on clocks 4,8,...,48 (12 pulses), en_a on 12,24,36,48 only, K=10, busy=0.
REQ-031 tune_req with tune_K=0x40 in IDLE -> K=0x40 next cycle, busy=mute=1 for 2 en_a pulses, then IDLE, locked=0.
REQ-032 K=10, K_min=10, K_max=50, step=10, threshold=100, scan_up, level=200 -> K=20, 2 settle + 4 measure en_a, locked=1, K stays 20.
REQ-033 Same band, level=0 always, scan_up -> K visits 20,30,40,50,10; then scan_fail pulse, K=10, locked=0, IDLE.
REQ-034 scan_down from K=10 with band 10..50 -> wrap to K=50; tune_req mid-MEASURE -> K=tune_K, scan aborted, no scan_fail.
REQ-035 scan_up and scan_down same cycle, or scan_up while busy -> ignored, state and K unchanged.

Source files
------------

// File: rtl/tuner_ctrl.sv
// Tuner sequencing controller: derives base-band/audio clock enables and runs the
// direct-tune / scan / settle / level-measure sequence that drives the DDS phase constant.
//
// state   | meaning
// IDLE    | waiting for tune or scan request, outputs unmuted
// SETTLE  | K just changed, muted while the channel settles
// MEASURE | muted, averaging DWELL level samples
// STEP    | one cycle: compute next scan K (with band wrap) or give up
module tuner_ctrl #(
  parameter int width_dds = 32,
  parameter int R1        = 250,
  parameter int R2        = 30,
  parameter int SETTLE    = 16,
  parameter int DWELL     = 64,
  parameter logic [width_dds-1:0] K_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 en_b,
  output logic                 en_a,
  input  logic                 tune_req,
  input  logic [width_dds-1:0] tune_K,
  input  logic                 scan_up,
  input  logic                 scan_down,
  input  logic [width_dds-1:0] step,
  input  logic [width_dds-1:0] K_min,
  input  logic [width_dds-1:0] K_max,
  input  logic [15:0]          level,
  input  logic [15:0]          threshold,
  output logic [width_dds-1:0] K,
  output logic                 busy,
  output logic                 mute,
  output logic                 locked,
  output logic                 scan_fail
);

  localparam int CB_W    = (R1 > 1) ? $clog2(R1) : 1;
  localparam int CA_W    = (R2 > 1) ? $clog2(R2) : 1;
  localparam int LOG_D   = $clog2(DWELL);
  localparam int ACC_W   = 16 + LOG_D;
  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CB_W-1:0]  CB_LAST   = CB_W'(R1 - 1);
  localparam logic [CA_W-1:0]  CA_LAST   = CA_W'(R2 - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_STEP} state_t;

  state_t               state, state_nxt;
  logic [CB_W-1:0]      cb;
  logic [CA_W-1:0]      ca;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [ACC_W-1:0]     acc, acc_d, acc_sum;
  logic [width_dds-1:0] k_q, k_d, start_k, start_k_d;
  logic                 mode_scan, mode_scan_d;
  logic                 dir_up, dir_up_d;
  logic                 wrap, wrap_d;
  logic                 locked_d, fail_d, busy_d, mute_d;

  logic                 scan_ok, hit, cnt_tc;
  logic [width_dds:0]   up_sum, lo_lim;
  logic [width_dds-1:0] step_k;
  logic                 wrap_hit, wrap_all, step_fail;

  // enable divider chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cb <= '0;
      ca <= '0;
    end else begin
      cb <= (cb == CB_LAST) ? '0 : cb + CB_W'(1);
      if (en_b) ca <= (ca == CA_LAST) ? '0 : ca + CA_W'(1);
    end
  end

  assign en_b = (cb == CB_LAST);
  assign en_a = en_b && (ca == CA_LAST);

  assign scan_ok = (scan_up ^ scan_down) && (K_min < K_max);
  assign cnt_tc  = (cnt == '0);
  assign acc_sum = acc + ACC_W'(level);
  assign hit     = (acc_sum[ACC_W-1:LOG_D] >= threshold);

  // scan step with band wrap; sums carry one extra bit so overflow cannot alias
  always_comb begin
    up_sum   = {1'b0, k_q} + {1'b0, step};
    lo_lim   = {1'b0, K_min} + {1'b0, step};
    step_k   = k_q;
    wrap_hit = 1'b0;
    if (dir_up) begin
      if (up_sum > {1'b0, K_max}) begin
        step_k   = K_min;
        wrap_hit = 1'b1;
      end else begin
        step_k = up_sum[width_dds-1:0];
      end
    end else begin
      if ({1'b0, k_q} < lo_lim) begin
        step_k   = K_max;
        wrap_hit = 1'b1;
      end else begin
        step_k = k_q - step;
      end
    end
    wrap_all  = wrap | wrap_hit;
    step_fail = wrap_all && (dir_up ? (step_k >= start_k) : (step_k <= start_k));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      k_q       <= K_RESET;
      start_k   <= K_RESET;
      mode_scan <= 1'b0;
      dir_up    <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      locked    <= 1'b0;
      scan_fail <= 1'b0;
      busy      <= 1'b0;
      mute      <= 1'b0;
    end else begin
      state     <= state_nxt;
      k_q       <= k_d;
      start_k   <= start_k_d;
      mode_scan <= mode_scan_d;
      dir_up    <= dir_up_d;
      wrap      <= wrap_d;
      cnt       <= cnt_d;
      acc       <= acc_d;
      locked    <= locked_d;
      scan_fail <= fail_d;
      busy      <= busy_d;
      mute      <= mute_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tune_req) begin
      state_nxt = S_SETTLE;
    end else begin
      case (state)
        S_IDLE:    if (scan_ok) state_nxt = S_STEP;
        S_STEP:    state_nxt = S_SETTLE;
        S_SETTLE:  if (en_a && cnt_tc) state_nxt = mode_scan ? S_MEASURE : S_IDLE;
        S_MEASURE: if (en_a && cnt_tc) state_nxt = hit ? S_IDLE : S_STEP;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    k_d         = k_q;
    start_k_d   = start_k;
    mode_scan_d = mode_scan;
    dir_up_d    = dir_up;
    wrap_d      = wrap;
    cnt_d       = cnt;
    acc_d       = acc;
    locked_d    = locked;
    fail_d      = 1'b0;
    if (tune_req) begin
      k_d         = tune_K;
      start_k_d   = tune_K;
      mode_scan_d = 1'b0;
      locked_d    = 1'b0;
      cnt_d       = SETTLE_LD;
    end else begin
      case (state)
        S_IDLE: begin
          if (scan_ok) begin
            start_k_d   = k_q;
            dir_up_d    = scan_up;
            wrap_d      = 1'b0;
            locked_d    = 1'b0;
            mode_scan_d = 1'b1;
          end
        end
        S_STEP: begin
          wrap_d = wrap_all;
          cnt_d  = SETTLE_LD;
          if (step_fail) begin
            k_d         = start_k;
            fail_d      = 1'b1;
            mode_scan_d = 1'b0;
          end else begin
            k_d = step_k;
          end
        end
        S_SETTLE: begin
          if (en_a) begin
            if (cnt_tc) begin
              cnt_d = DWELL_LD;
              acc_d = '0;
            end else begin
              cnt_d = cnt - CNT_W'(1);
            end
          end
        end
        S_MEASURE: begin
          if (en_a) begin
            if (cnt_tc) begin
              if (hit) locked_d = 1'b1;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_nxt != S_IDLE);
    mute_d = (state_nxt != S_IDLE);
  end

  assign K = k_q;

endmodule

// File: tb/tb_tuner_ctrl.sv
// Directed bench for tuner_ctrl: enable cadence, direct tune, scan lock / fail / wrap,
// aborts, ignored requests and mid-scan reset. K changes are checked against a queue.
module tb_tuner_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_b, en_a;
  logic         tune_req;
  logic [W-1:0] tune_K;
  logic         scan_up, scan_down;
  logic [W-1:0] step, K_min, K_max;
  logic [15:0]  level, threshold;
  logic [W-1:0] K;
  logic         busy, mute, locked, scan_fail;

  int checks   = 0;
  int failures = 0;
  int fail_cnt = 0;
  logic         mon_on = 1'b0;
  logic [W-1:0] k_prev;
  logic [W-1:0] exp_q[$];

  tuner_ctrl #(
    .width_dds(W), .R1(4), .R2(3), .SETTLE(2), .DWELL(4), .K_RESET(8'd10)
  ) dut (
    .clk(clk), .reset(reset), .en_b(en_b), .en_a(en_a),
    .tune_req(tune_req), .tune_K(tune_K), .scan_up(scan_up), .scan_down(scan_down),
    .step(step), .K_min(K_min), .K_max(K_max), .level(level), .threshold(threshold),
    .K(K), .busy(busy), .mute(mute), .locked(locked), .scan_fail(scan_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every K change popped against the expected queue
  always @(negedge clk) begin
    if (mon_on && (K !== k_prev)) begin
      if (exp_q.size() == 0) begin
        check("k_unexpected_change", {24'h0, K}, {24'h0, k_prev});
      end else begin
        check("k_sequence", {24'h0, K}, {24'h0, exp_q.pop_front()});
      end
      k_prev = K;
    end
    if (scan_fail === 1'b1) fail_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ena_high(input string tag);
    int n = 0;
    while (en_a !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, en_a, 1'b1);
  endtask

  task automatic wait_ena(input string tag);
    wait_ena_high(tag);
    tick();
  endtask

  task automatic do_tune(input logic [W-1:0] val);
    exp_q.push_back(val);
    tune_K   = val;
    tune_req = 1'b1;
    tick();
    tune_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b0; tune_req = 1'b0; tune_K = '0; scan_up = 1'b0; scan_down = 1'b0;
    step = 8'd10; K_min = 8'd10; K_max = 8'd50; level = '0; threshold = 16'd100;
    repeat (3) tick();
    check("rst_K", K, 8'd10);
    check("rst_busy", busy, 1'b0);
    check("rst_mute", mute, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_scan_fail", scan_fail, 1'b0);
    check("rst_en_b", en_b, 1'b0);
    check("rst_en_a", en_a, 1'b0);
    k_prev = K;
    mon_on = 1'b1;

    // enable cadence over 48 clocks
    reset = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      check("cad_en_b", en_b, (c % 4) == 0);
      check("cad_en_a", en_a, (c % 12) == 0);
      tick();
    end
    check("cad_K", K, 8'd10);
    check("cad_busy", busy, 1'b0);

    // direct tune
    do_tune(8'h40);
    check("tune_K", K, 8'h40);
    check("tune_busy", busy, 1'b1);
    check("tune_mute", mute, 1'b1);
    wait_ena("tune_ena1");
    check("tune_busy_mid", busy, 1'b1);
    wait_ena("tune_ena2");
    check("tune_idle", busy, 1'b0);
    check("tune_unmute", mute, 1'b0);
    check("tune_locked", locked, 1'b0);

    // scan up, station found at first step
    do_tune(8'd10);
    wait_ena("pre_ena1");
    wait_ena("pre_ena2");
    level = 16'd200;
    exp_q.push_back(8'd20);
    scan_up = 1'b1;
    tick();
    scan_up = 1'b0;
    check("lock_step_K", K, 8'd10);
    check("lock_step_busy", busy, 1'b1);
    tick();
    check("lock_K20", K, 8'd20);
    wait_ena("lock_s1");
    wait_ena("lock_s2");
    check("lock_measuring", mute, 1'b1);
    wait_ena("lock_m1");
    wait_ena("lock_m2");
    wait_ena("lock_m3");
    check("lock_before_4th", locked, 1'b0);
    wait_ena("lock_m4");
    check("lock_locked", locked, 1'b1);
    check("lock_idle", busy, 1'b0);
    check("lock_K_hold", K, 8'd20);

    // scan up with no station: full band then give up
    do_tune(8'd10);
    check("retune_clears_lock", locked, 1'b0);
    wait_ena("pre2_ena1");
    wait_ena("pre2_ena2");
    level = 16'd0;
    exp_q.push_back(8'd20); exp_q.push_back(8'd30); exp_q.push_back(8'd40);
    exp_q.push_back(8'd50); exp_q.push_back(8'd10);
    scan_up = 1'b1;
    tick();
    scan_up = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
    check("fail_done", busy, 1'b0);
    check("fail_pulses", fail_cnt, 1);
    check("fail_K", K, 8'd10);
    check("fail_locked", locked, 1'b0);
    check("fail_mute", mute, 1'b0);

    // scan down wraps to top of band, then aborted by tune on an en_a cycle
    exp_q.push_back(8'd50);
    scan_down = 1'b1;
    tick();
    scan_down = 1'b0;
    tick();
    check("down_K50", K, 8'd50);
    wait_ena("down_s1");
    wait_ena("down_s2");
    wait_ena("down_m1");
    wait_ena_high("down_m2");
    do_tune(8'h33);
    check("abort_K", K, 8'h33);
    check("abort_busy", busy, 1'b1);
    wait_ena("abort_s1");
    check("abort_settle_restart", busy, 1'b1);
    wait_ena("abort_s2");
    check("abort_idle", busy, 1'b0);
    check("abort_locked", locked, 1'b0);
    check("abort_no_fail", fail_cnt, 1);

    // ignored scan requests
    scan_up = 1'b1; scan_down = 1'b1;
    tick();
    scan_up = 1'b0; scan_down = 1'b0;
    check("both_ignored_busy", busy, 1'b0);
    check("both_ignored_K", K, 8'h33);
    K_min = 8'd50; K_max = 8'd10;
    scan_up = 1'b1;
    tick();
    scan_up = 1'b0;
    check("band_inv_ignored", busy, 1'b0);
    K_min = 8'd50; K_max = 8'd50;
    scan_down = 1'b1;
    tick();
    scan_down = 1'b0;
    check("band_eq_ignored", busy, 1'b0);
    K_min = 8'd10; K_max = 8'd50;
    do_tune(8'h20);
    scan_up = 1'b1;
    tick();
    scan_up = 1'b0;
    check("busy_scan_K", K, 8'h20);
    wait_ena("busy_s1");
    wait_ena("busy_s2");
    check("busy_scan_ignored", busy, 1'b0);
    check("busy_scan_K_end", K, 8'h20);

    // reset in the middle of a scan
    exp_q.push_back(8'h2A);
    scan_up = 1'b1;
    tick();
    scan_up = 1'b0;
    tick();
    check("mid_K", K, 8'h2A);
    wait_ena("mid_s1");
    exp_q.push_back(8'd10);
    reset = 1'b0;
    #1;
    check("mid_rst_K", K, 8'd10);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mute", mute, 1'b0);
    check("mid_rst_en_b", en_b, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      check("post_rst_en_b", en_b, c == 4);
      tick();
    end
    check("post_rst_no_fail", fail_cnt, 1);
    check("post_rst_busy", busy, 1'b0);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
